// File: rtl/sys_bus_xbar.sv
// ============================================================================
// Module   : sys_bus_xbar
// Brief    : Registered single-master bus decoder. Routes one req/ack
//            transaction at a time to NSLV address windows and reports decode
//            misses and slave timeouts as bus errors.
//            Optional error log enabled by `define SYS_BUS_ERR_LOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sys_bus_xbar #(
  parameter int                     ADDR_W   = 64,
  parameter int                     DATA_W   = 64,
  parameter int                     NSLV     = 4,
  parameter logic [NSLV*ADDR_W-1:0] SLV_BASE = {64'h80000000, 64'h50000000,
                                                64'h40000000, 64'h00000000},
  parameter logic [NSLV*ADDR_W-1:0] SLV_SIZE = {64'h1000, 64'h10,
                                                64'h10, 64'h4000},
  parameter int                     TIMEOUT  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m_req,
  input  logic [ADDR_W-1:0]      m_addr,
  input  logic [DATA_W-1:0]      m_wdata,
  input  logic [2:0]             m_rd_ctrl,
  input  logic [2:0]             m_wr_ctrl,
  output logic                   m_ready,
  output logic                   m_rvalid,
  output logic [DATA_W-1:0]      m_rdata,
  output logic                   m_err,
`ifdef SYS_BUS_ERR_LOG_EN
  output logic [ADDR_W-1:0]      err_addr,
  output logic [15:0]            err_cnt,
`endif
  output logic [NSLV-1:0]        s_req,
  output logic [ADDR_W-1:0]      s_addr,
  output logic [DATA_W-1:0]      s_wdata,
  output logic [2:0]             s_rd_ctrl,
  output logic [2:0]             s_wr_ctrl,
  input  logic [NSLV-1:0]        s_ack,
  input  logic [NSLV*DATA_W-1:0] s_rdata
);

  localparam int              CNT_W     = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_ACCESS = 2'd1;
  localparam logic [1:0] c_ST_RESP   = 2'd2;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [NSLV-1:0]   r_s_req;
  logic [ADDR_W-1:0] r_s_addr;
  logic [DATA_W-1:0] r_s_wdata;
  logic [2:0]        r_s_rd_ctrl;
  logic [2:0]        r_s_wr_ctrl;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic [NSLV-1:0]   w_hit;
  logic [NSLV-1:0]   w_sel;
  logic [DATA_W-1:0] w_rdata;
  logic              w_ack;

  // Window check is done as offset compare so the window never wraps.
  for (genvar i = 0; i < NSLV; i++) begin : g_dec
    assign w_hit[i] = (m_addr >= SLV_BASE[i*ADDR_W +: ADDR_W]) &&
                      ((m_addr - SLV_BASE[i*ADDR_W +: ADDR_W]) <
                       SLV_SIZE[i*ADDR_W +: ADDR_W]);
  end

  // Isolate lowest set bit so overlapping windows resolve to the lowest index.
  assign w_sel = w_hit & (~w_hit + NSLV'(1));
  assign w_ack = |(s_ack & r_s_req);

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (r_s_req[i]) begin
        w_rdata = w_rdata | s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_ST_IDLE;
      r_cnt       <= '0;
      r_s_req     <= '0;
      r_s_addr    <= '0;
      r_s_wdata   <= '0;
      r_s_rd_ctrl <= '0;
      r_s_wr_ctrl <= '0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (m_req) begin
            r_s_addr    <= m_addr;
            r_s_wdata   <= m_wdata;
            r_s_rd_ctrl <= m_rd_ctrl;
            r_s_wr_ctrl <= m_wr_ctrl;
            r_cnt       <= '0;
            if (|w_sel) begin
              r_s_req <= w_sel;
              r_state <= c_ST_ACCESS;
            end else begin
              r_rvalid <= 1'b1;
              r_err    <= 1'b1;
              r_rdata  <= '0;
              r_state  <= c_ST_RESP;
            end
          end
        end
        c_ST_ACCESS: begin
          if (w_ack) begin
            r_s_req  <= '0;
            r_rvalid <= 1'b1;
            r_err    <= 1'b0;
            r_rdata  <= (r_s_rd_ctrl != 3'd0) ? w_rdata : '0;
            r_state  <= c_ST_RESP;
          end else if (r_cnt == c_CNT_MAX) begin
            r_s_req  <= '0;
            r_rvalid <= 1'b1;
            r_err    <= 1'b1;
            r_rdata  <= '0;
            r_state  <= c_ST_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        c_ST_RESP: begin
          r_rvalid <= 1'b0;
          r_cnt    <= '0;
          r_state  <= c_ST_IDLE;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

`ifdef SYS_BUS_ERR_LOG_EN
  logic [ADDR_W-1:0] r_err_addr;
  logic [15:0]       r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_addr <= '0;
      r_err_cnt  <= '0;
    end else if (r_state == c_ST_RESP && r_err) begin
      r_err_addr <= r_s_addr;
      if (r_err_cnt != 16'hFFFF) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign err_addr = r_err_addr;
  assign err_cnt  = r_err_cnt;
`endif

  assign m_ready   = (r_state == c_ST_IDLE) && !rst;
  assign m_rvalid  = r_rvalid;
  assign m_rdata   = r_rdata;
  assign m_err     = r_err;
  assign s_req     = r_s_req;
  assign s_addr    = r_s_addr;
  assign s_wdata   = r_s_wdata;
  assign s_rd_ctrl = r_s_rd_ctrl;
  assign s_wr_ctrl = r_s_wr_ctrl;

endmodule

`default_nettype wire

// File: tb/tb_sys_bus_xbar.sv
// ============================================================================
// Module   : tb_sys_bus_xbar
// Brief    : Scoreboard bench for sys_bus_xbar with a reactive slave model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sys_bus_xbar;

  localparam int TO = 16;
  localparam logic [63:0] BASES [4] = '{64'h0000_0000, 64'h4000_0000,
                                        64'h5000_0000, 64'h8000_0000};
  localparam logic [63:0] SIZES [4] = '{64'h4000, 64'h10, 64'h10, 64'h1000};

  typedef struct {
    int          cyc;
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         m_req;
  logic [63:0]  m_addr;
  logic [63:0]  m_wdata;
  logic [2:0]   m_rd_ctrl;
  logic [2:0]   m_wr_ctrl;
  logic         m_ready;
  logic         m_rvalid;
  logic [63:0]  m_rdata;
  logic         m_err;
  logic [3:0]   s_req;
  logic [63:0]  s_addr;
  logic [63:0]  s_wdata;
  logic [2:0]   s_rd_ctrl;
  logic [2:0]   s_wr_ctrl;
  logic [3:0]   s_ack;
  logic [255:0] s_rdata;
`ifdef SYS_BUS_ERR_LOG_EN
  logic [63:0]  err_addr;
  logic [15:0]  err_cnt;
`endif

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb[$];

  // Current transaction as seen by the slave model.
  logic [3:0]  exp_sel;
  int          t_sel;
  int          t_dly;
  logic [63:0] t_data, t_addr, t_wd;
  logic [2:0]  t_rd, t_wr;
  int          req_cnt;
  int          model_errs;
  logic [63:0] model_err_addr;

  sys_bus_xbar #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rd_ctrl(m_rd_ctrl), .m_wr_ctrl(m_wr_ctrl),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
`ifdef SYS_BUS_ERR_LOG_EN
    .err_addr(err_addr), .err_cnt(err_cnt),
`endif
    .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rd_ctrl(s_rd_ctrl), .s_wr_ctrl(s_wr_ctrl),
    .s_ack(s_ack), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic int model_decode(input logic [63:0] a);
    for (int i = 0; i < 4; i++)
      if (a >= BASES[i] && a < BASES[i] + SIZES[i]) return i;
    return -1;
  endfunction

  // Slave model: acks the expected slave t_dly cycles into its request.
  always @(negedge clk) begin
    s_ack = 4'b0;
    for (int i = 0; i < 4; i++) s_rdata[i*64 +: 64] = {$urandom, $urandom};
    if (s_req != 4'b0) begin
      if (req_cnt == 0) begin
        chk("s_req_onehot", 64'(s_req), 64'(exp_sel));
        chk("s_addr", s_addr, t_addr);
        chk("s_wdata", s_wdata, t_wd);
        chk("s_ctrl", 64'({s_rd_ctrl, s_wr_ctrl}), 64'({t_rd, t_wr}));
        chk("m_ready_busy", 64'(m_ready), 64'd0);
      end
      if (t_sel >= 0) s_rdata[t_sel*64 +: 64] = t_data;
      if (req_cnt == t_dly) s_ack = exp_sel;
      s_ack = s_ack | (4'($urandom) & ~exp_sel);
      req_cnt++;
    end else begin
      req_cnt = 0;
    end
  end

  // Monitor: every response strobe pops one expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_rvalid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rvalid", 64'(m_rvalid), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rvalid_cycle", 64'(cyc), 64'(e.cyc));
          chk("m_rdata", m_rdata, e.rdata);
          chk("m_err", 64'(m_err), 64'(e.err));
        end
      end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
        chk("rvalid_missing", 64'(cyc), 64'(sb[0].cyc));
        void'(sb.pop_front());
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!m_ready && n < 200) begin @(negedge clk); n++; end
    if (!m_ready) chk("ready_timeout", 64'(m_ready), 64'd1);
  endtask

  task automatic do_txn(input logic [63:0] addr, input logic [2:0] rd,
                        input logic [2:0] wr, input logic [63:0] wd,
                        input int dly, input logic [63:0] data);
    exp_t e;
    int   sel, n;
    logic acked;
    wait_ready();
    sel     = model_decode(addr);
    acked   = (sel >= 0) && (dly >= 0) && (dly <= TO - 1);
    exp_sel = (sel >= 0) ? 4'(1 << sel) : 4'b0;
    t_sel = sel; t_dly = dly; t_data = data;
    t_addr = addr; t_wd = wd; t_rd = rd; t_wr = wr;
    e.err   = !acked;
    e.rdata = (!acked || rd == 3'd0) ? 64'd0 : data;
    e.cyc   = cyc + ((sel < 0) ? 1 : (acked ? 2 + dly : TO + 1));
    if (e.err) begin model_errs++; model_err_addr = addr; end
    sb.push_back(e);
    m_req = 1'b1; m_addr = addr; m_wdata = wd; m_rd_ctrl = rd; m_wr_ctrl = wr;
    // m_req stays high through ACCESS/RESP to expose double acceptance.
    n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    m_req = 1'b0;
    if (sb.size() != 0) begin
      chk("response_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  initial begin
    logic [63:0] a;
    int s, q, d;
    rst = 1'b1; m_req = 1'b0; m_addr = '0; m_wdata = '0;
    m_rd_ctrl = '0; m_wr_ctrl = '0; s_ack = '0; s_rdata = '0;
    exp_sel = '0; t_sel = -1; t_dly = -1; t_data = '0; t_addr = '0;
    t_wd = '0; t_rd = '0; t_wr = '0; req_cnt = 0;
    model_errs = 0; model_err_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_m_ready", 64'(m_ready), 64'd0);
    chk("rst_m_rvalid", 64'(m_rvalid), 64'd0);
    chk("rst_m_rdata", m_rdata, 64'd0);
    chk("rst_m_err", 64'(m_err), 64'd0);
    chk("rst_s_req", 64'(s_req), 64'd0);
    chk("rst_s_addr_wdata", s_addr | s_wdata, 64'd0);
    chk("rst_s_ctrl", 64'({s_rd_ctrl, s_wr_ctrl}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(m_ready), 64'd1);

    do_txn(64'h8000_0008, 3'd3, 3'd0, 64'd0, 0, 64'h1122334455667788);
    do_txn(64'h4000_0004, 3'd0, 3'b010, 64'hA5, 2, 64'hDEAD);
    do_txn(64'h6000_0000, 3'd3, 3'd0, 64'd0, 0, 64'hBEEF);
    do_txn(64'h5000_0000, 3'd3, 3'd0, 64'd0, -1, 64'h1);
    do_txn(64'h5000_0008, 3'd1, 3'd0, 64'd0, TO - 1, 64'h77);
    do_txn(64'h0000_3FFF, 3'd1, 3'd0, 64'd0, 0, 64'h3F);
    do_txn(64'h0000_4000, 3'd1, 3'd0, 64'd0, 0, 64'h40);
    do_txn(64'h8000_0FFF, 3'd1, 3'd0, 64'd0, 1, 64'hFF);
    do_txn(64'h8000_1000, 3'd1, 3'd0, 64'd0, 0, 64'h10);
    do_txn(64'h0000_0100, 3'd0, 3'd0, 64'd0, 0, 64'h55);

    // Abandon a DRAM access by resetting in its second request cycle.
    wait_ready();
    exp_sel = 4'b1000; t_sel = 3; t_dly = -1; t_data = '0;
    t_addr = 64'h8000_0010; t_wd = 64'h9; t_rd = 3'd3; t_wr = 3'd0;
    m_req = 1'b1; m_addr = t_addr; m_wdata = t_wd; m_rd_ctrl = t_rd; m_wr_ctrl = t_wr;
    @(negedge clk);
    m_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_s_req", 64'(s_req), 64'd0);
    chk("midrst_rvalid", 64'(m_rvalid), 64'd0);
    rst = 1'b0;
    model_errs = 0; model_err_addr = '0;
    repeat (20) @(negedge clk);
    do_txn(64'h8000_0020, 3'd3, 3'd0, 64'd0, 1, 64'hCAFEF00D12345678);

    for (int k = 0; k < 40; k++) begin
      q = $urandom_range(0, 9);
      s = $urandom_range(0, 3);
      if (q < 6)       a = BASES[s] + 64'($urandom % 32'(SIZES[s]));
      else if (q == 6) a = BASES[s] + SIZES[s];
      else if (q == 7) a = BASES[s] + SIZES[s] - 64'd1;
      else             a = {$urandom, $urandom};
      q = $urandom_range(0, 9);
      if (q < 7)       d = $urandom_range(0, 4);
      else if (q == 7) d = -1;
      else if (q == 8) d = TO - 1;
      else             d = TO;
      do_txn(a, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             {$urandom, $urandom}, d, {$urandom, $urandom});
    end

    repeat (5) @(negedge clk);
`ifdef SYS_BUS_ERR_LOG_EN
    chk("err_cnt", 64'(err_cnt), 64'(model_errs));
    chk("err_addr", err_addr, model_err_addr);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
